// File: rtl/fdiv_issue_ctrl_if.sv
// Request, pipeline-operand and response signals of the divide issue/retire controller.
// The controller takes the slave modport; the requester/consumer/pipeline side takes master.
interface fdiv_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      div_a;
    logic [31:0]      div_b;
    logic [31:0]      div_result;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_result;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    modport slave (
        input  req_valid, req_a, req_b, req_tag, div_result, resp_ready,
        output req_ready, div_a, div_b, resp_valid, resp_result, resp_tag, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_tag, div_result, resp_ready,
        input  req_ready, div_a, div_b, resp_valid, resp_result, resp_tag, busy
    );
endinterface

// File: rtl/fdiv_issue_ctrl.sv
// Issue/retire controller for a fixed-latency, non-stallable divide pipeline.
// Issue is credit-limited so every result that retires always finds room in the response FIFO.
module fdiv_issue_ctrl #(
    parameter int LATENCY    = 7,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    fdiv_issue_ctrl_if.slave bus
);
    localparam int INF_W = $clog2(LATENCY + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SUM_W = $clog2(LATENCY + FIFO_DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      result;
    } resp_t;

    logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [TAG_W-1:0]   tag_sr_q [LATENCY];
    logic [TAG_W-1:0]   tag_sr_d [LATENCY];
    logic [INF_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    resp_t              fifo_mem_q [FIFO_DEPTH];

    logic [SUM_W-1:0]   credit_used;
    logic               accept;
    logic               retire;
    logic               push;
    logic               pop;
    logic               resp_valid;
    resp_t              head;

    // Credits come from registered counts only, so resp_ready never reaches req_ready.
    assign credit_used   = SUM_W'(inflight_q) + SUM_W'(fifo_cnt_q);
    assign bus.req_ready = !rst && !flush && (credit_used < SUM_W'(FIFO_DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.div_a = bus.req_a;
    assign bus.div_b = bus.req_b;

    assign retire = vld_sr_q[LATENCY-1];
    assign push   = retire && !rst && !flush;

    assign resp_valid      = (fifo_cnt_q != '0);
    assign pop             = resp_valid && bus.resp_ready;
    assign head            = fifo_mem_q[rd_ptr_q];
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_result = resp_valid ? head.result : '0;
    assign bus.resp_tag    = resp_valid ? head.tag : '0;
    assign bus.busy        = (inflight_q != '0) || resp_valid;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        vld_sr_d    = '0;
        vld_sr_d[0] = accept;
        tag_sr_d[0] = bus.req_tag;
        for (int i = 1; i < LATENCY; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
            tag_sr_d[i] = tag_sr_q[i-1];
        end

        inflight_d = inflight_q;
        unique case ({accept, retire})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase

        fifo_cnt_d = fifo_cnt_q;
        unique case ({retire, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        wr_ptr_d = retire ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        // A flush voids this cycle's pop and retire along with everything tracked so far.
        if (flush) begin
            vld_sr_d   = '0;
            inflight_d = '0;
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr_q   <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            vld_sr_q   <= vld_sr_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // NOTE: tag and FIFO storage are not reset; valid bits and counts qualify them, and outputs are gated.
    always_ff @(posedge clk) begin
        tag_sr_q <= tag_sr_d;
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= '{tag: tag_sr_q[LATENCY-1], result: bus.div_result};
        end
    end
endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Directed and random bench for fdiv_issue_ctrl with a fixed-latency pipeline model
// and an in-order scoreboard filled at acceptance and drained at each response transfer.
module tb_fdiv_issue_ctrl;
    localparam int LATENCY    = 7;
    localparam int FIFO_DEPTH = 8;
    localparam int TAG_W      = 5;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      result;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    fdiv_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    fdiv_issue_ctrl #(
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in divide datapath: any deterministic function of the operands exposes routing/alignment faults.
    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
        return (a ^ {b[15:0], b[31:16]}) + (b ^ 32'h9E37_79B9);
    endfunction

    logic [31:0] pipe_q [LATENCY];
    always @(posedge clk) begin
        pipe_q[0] <= div_model(bus.div_a, bus.div_b);
        for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign bus.div_result = pipe_q[LATENCY-1];

    int   total   = 0;
    int   bad     = 0;
    int   rsp_cnt = 0;
    bit   mon_en  = 1'b0;
    exp_t exp_q [$];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on every completed response transfer.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst || flush) begin
                exp_q.delete();
            end else begin
                if (bus.req_valid && bus.req_ready)
                    exp_q.push_back('{tag: bus.req_tag, result: div_model(bus.req_a, bus.req_b)});
                if (bus.resp_valid && bus.resp_ready) begin
                    rsp_cnt++;
                    check("resp_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("resp_data", {bus.resp_tag, bus.resp_result}, exp_q.pop_front());
                end
                check("credit_bound", (dut.inflight_q + dut.fifo_cnt_q) <= FIFO_DEPTH, 1);
                check("push_when_full", dut.vld_sr_q[LATENCY-1] && (dut.fifo_cnt_q == FIFO_DEPTH), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int tag, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_tag   = TAG_W'(tag);
        bus.req_a     = a;
        bus.req_b     = b;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", bus.busy, 0);
    endtask

    function automatic logic [31:0] rand_normal();
        logic [7:0] e;
        e = 8'($urandom_range(254, 1));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  tagn;
        int  rx0;
        int  sent;
        int  cyc;
        bit  fire;

        rst = 1'b1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_tag = '0;
        bus.resp_ready = 1'b0;

        // Reset values
        step();
        step();
        mon_en = 1'b1;
        bus.req_a = 32'h1234_5678;
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_resp_tag", bus.resp_tag, 0);
        check("rst_resp_result", bus.resp_result, 0);
        check("div_a_follow", bus.div_a, 32'h1234_5678);
        rst = 1'b0;
        #1;
        check("post_rst_ready", bus.req_ready, 1);

        // Single op: accept in cycle 0, response in cycle 8
        step();
        bus.resp_ready = 1'b1;
        drive(3, 32'h40C0_0000, 32'h4040_0000);
        #1;
        check("single_accept", bus.req_ready, 1);
        step();
        bus.req_valid = 1'b0;
        for (int c = 1; c < LATENCY + 1; c++) begin
            #1;
            check("single_early", bus.resp_valid, 0);
            check("single_busy", bus.busy, 1);
            step();
        end
        check("single_valid", bus.resp_valid, 1);
        check("single_tag", bus.resp_tag, 3);
        check("single_result", bus.resp_result, div_model(32'h40C0_0000, 32'h4040_0000));
        step();
        check("single_done_valid", bus.resp_valid, 0);
        check("single_done_busy", bus.busy, 0);

        // Fill with consumer stalled: exactly FIFO_DEPTH accepts
        bus.resp_ready = 1'b0;
        tagn = 0;
        for (int c = 0; c < 24; c++) begin
            drive(tagn, 32'h3F80_0000 + 32'(tagn), 32'h4000_0000 ^ (32'(tagn) << 3));
            #1;
            check("fill_ready", bus.req_ready, c < FIFO_DEPTH);
            if (bus.req_valid && bus.req_ready) tagn++;
            step();
        end
        check("fill_accepts", tagn, FIFO_DEPTH);

        // Credit release: one pop in T opens exactly one slot in T+1
        bus.resp_ready = 1'b1;
        #1;
        check("release_same_cycle", bus.req_ready, 0);
        check("release_head_tag", bus.resp_tag, 0);
        step();
        bus.resp_ready = 1'b0;
        #1;
        check("release_next_cycle", bus.req_ready, 1);
        step();
        check("release_closed_again", bus.req_ready, 0);
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        for (int i = 1; i < FIFO_DEPTH; i++) begin
            #1;
            check("drain_valid", bus.resp_valid, 1);
            check("drain_tag", bus.resp_tag, i);
            step();
        end
        wait_idle(40);

        // Flush with 2 buffered and 3 in flight
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(10 + i, 32'h4100_0000 + 32'(i), 32'h3F00_0000);
            step();
        end
        bus.req_valid = 1'b0;
        repeat (LATENCY + 1) step();
        for (int i = 0; i < 3; i++) begin
            drive(12 + i, 32'h4200_0000 + 32'(i), 32'h3E00_0000);
            step();
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_ready_low", bus.req_ready, 0);
        check("flush_resp_visible", bus.resp_valid, 1);
        rx0 = rsp_cnt;
        step();
        flush = 1'b0;
        #1;
        check("flush_after_valid", bus.resp_valid, 0);
        check("flush_after_busy", bus.busy, 0);
        check("flush_after_ready", bus.req_ready, 1);
        for (int c = 0; c < 2 * LATENCY; c++) begin
            step();
            check("flush_quiet", bus.resp_valid, 0);
        end
        check("flush_no_resp", rsp_cnt - rx0, 0);

        // Reset mid-stream with 5 ops outstanding
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(20 + i, 32'h4300_0000 + 32'(i), 32'h3D00_0000);
            step();
        end
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", bus.req_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", bus.resp_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_tag", bus.resp_tag, 0);
        check("mid_rst_result", bus.resp_result, 0);
        check("mid_rst_ready_after", bus.req_ready, 1);
        rx0 = rsp_cnt;
        bus.resp_ready = 1'b1;
        drive(9, 32'h4110_0000, 32'h4020_0000);
        step();
        bus.req_valid = 1'b0;
        for (int c = 1; c < LATENCY + 1; c++) begin
            #1;
            check("mid_rst_early", bus.resp_valid, 0);
            step();
        end
        check("mid_rst_new_valid", bus.resp_valid, 1);
        check("mid_rst_new_tag", bus.resp_tag, 9);
        repeat (2 * LATENCY) step();
        check("mid_rst_alone", rsp_cnt - rx0, 1);

        // Random stress
        rx0 = rsp_cnt;
        sent = 0;
        cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            if (!bus.req_valid && $urandom_range(99) < 70)
                drive(int'($urandom_range(31)), rand_normal(), rand_normal());
            bus.resp_ready = ($urandom_range(3) != 0);
            #1;
            fire = bus.req_valid && bus.req_ready;
            if (fire) sent++;
            step();
            cyc++;
            if (fire) bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        check("stress_sent", sent, 1000);
        bus.resp_ready = 1'b1;
        wait_idle(200);
        check("stress_rx", rsp_cnt - rx0, 1000);
        check("stress_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
